// File: rtl/scratchpad_mem.sv
// Scratchpad array: two combinational core read ports, one core write port, and a
// host load/debug port that briefly stalls the core. The array is zeroed after reset.
module scratchpad_mem #(
  parameter int width      = 8,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] addr1,
  input  logic [addr_width-1:0] addr2,
  output logic [width-1:0]      rdata1,
  output logic [width-1:0]      rdata2,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [width-1:0]      wdata,
  output logic                  core_stall,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [addr_width-1:0] host_addr,
  input  logic [width-1:0]      host_wdata,
  output logic [width-1:0]      host_rdata,
  output logic                  host_rvalid
);
  localparam int DEPTH = 1 << addr_width;
  localparam logic [addr_width-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {CLEAR, IDLE, HOST} state_t;

  typedef struct packed {
    logic                  we;
    logic [addr_width-1:0] addr;
    logic [width-1:0]      wdata;
  } host_req_t;

  state_t                state;
  logic [addr_width-1:0] clr_cnt;
  host_req_t             req;
  logic [width-1:0]      mem [DEPTH];

  assign rdata1 = mem[addr1];
  assign rdata2 = mem[addr2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      req         <= '0;
      host_rvalid <= 1'b0;
      core_stall  <= 1'b1;
      host_ready  <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + CNT_ONE;
          if (&clr_cnt) begin
            state      <= IDLE;
            core_stall <= 1'b0;
            host_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (host_valid && host_ready) begin
            req        <= '{we: host_we, addr: host_addr, wdata: host_wdata};
            state      <= HOST;
            core_stall <= 1'b1;
            host_ready <= 1'b0;
          end
        end
        HOST: begin
          host_rvalid <= !req.we;
          state       <= IDLE;
          core_stall  <= 1'b0;
          host_ready  <= 1'b1;
        end
        default: begin
          state      <= CLEAR;
          clr_cnt    <= '0;
          core_stall <= 1'b1;
          host_ready <= 1'b0;
        end
      endcase
    end
  end

  // Host read samples the array after the accept cycle, so a core write in that cycle wins.
  always_ff @(posedge clk) begin
    if (reset)
      host_rdata <= '0;
    else if (state == HOST && !req.we)
      host_rdata <= mem[req.addr];
  end

  // No array reset; a request caught by reset mid-HOST is simply dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state)
        CLEAR:   mem[clr_cnt] <= '0;
        IDLE:    if (we) mem[waddr] <= wdata;
        HOST:    if (req.we) mem[req.addr] <= req.wdata;
        default: ;
      endcase
    end
  end
endmodule
